sdram_dma_ctrl: RTL

//  Command/stream front end that drives the sdram_mac register interface (256x32 buffer, address reg, length reg).

---
 rtl/sdram_dma_ctrl_if.sv | 34 +++
 rtl/sdram_dma_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_dma_ctrl_if.sv
// Command, stream and sdram_mac register-port bundle of the SDRAM DMA front end.
// master = the controller, slave = the command source, stream partners and MAC.
interface sdram_dma_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_nw_m1;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        done;
  logic        err;
  logic [31:0] mac_wd;
  logic [31:0] mac_rd;
  logic [7:0]  mac_addr;
  logic        mac_we;
  logic        mac_we_a;
  logic        mac_we_len;
  logic        mac_busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_nw_m1, s_data, s_valid, m_ready, mac_rd, mac_busy,
    output cmd_ready, s_ready, m_data, m_valid, done, err, mac_wd, mac_addr, mac_we, mac_we_a, mac_we_len
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_nw_m1, s_data, s_valid, m_ready, mac_rd, mac_busy,
    input  cmd_ready, s_ready, m_data, m_valid, done, err, mac_wd, mac_addr, mac_we, mac_we_a, mac_we_len
  );
endinterface

// File: rtl/sdram_dma_ctrl.sv
// Command/stream front end for the sdram_mac register port: fills or drains the
// 256x32 MAC buffer and programs the address/length registers, one command at a time.
module sdram_dma_ctrl #(
  parameter int BUSY_TIMEOUT = 64,
  parameter int RD_LATENCY   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  sdram_dma_ctrl_if.master bus_if
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FILL    = 3'd1;
  localparam logic [2:0] SET_A   = 3'd2;
  localparam logic [2:0] SET_LEN = 3'd3;
  localparam logic [2:0] WAIT_HI = 3'd4;
  localparam logic [2:0] WAIT_LO = 3'd5;
  localparam logic [2:0] DRAIN   = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  logic [2:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  nw_q, nw_d;
  logic [7:0]  mac_addr_q, mac_addr_d;
  logic [31:0] mac_wd_q, mac_wd_d;
  logic        mac_we_q, mac_we_d;
  logic        mac_we_a_q, mac_we_a_d;
  logic        mac_we_len_q, mac_we_len_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pop_q, pop_d;
  logic        inflight_q, inflight_d;
  logic [1:0]  occ_q, occ_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic [31:0] skid_q [2];

  logic       m_valid_w, pop_w, issue_w, cap_w, lat_infl_w;
  logic [2:0] base_w;

  assign m_valid_w  = (state_q == DRAIN) && (occ_q != 2'd0);
  assign pop_w      = m_valid_w && bus_if.m_ready;
  assign lat_infl_w = (RD_LATENCY != 0) && inflight_q;
  // Issue a buffer read only if its word is guaranteed a skid slot when it lands.
  assign base_w     = {1'b0, occ_q} - {2'b00, pop_w} + {2'b00, lat_infl_w};
  assign issue_w    = (state_q == DRAIN) && (cnt_q <= {8'd0, nw_q}) && (base_w < 3'd2);
  assign cap_w      = (RD_LATENCY == 0) ? issue_w : inflight_q;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    nw_d         = nw_q;
    mac_addr_d   = mac_addr_q;
    mac_wd_d     = mac_wd_q;
    mac_we_d     = 1'b0;
    mac_we_a_d   = 1'b0;
    mac_we_len_d = 1'b0;
    err_d        = err_q;
    cnt_d        = cnt_q;
    pop_d        = pop_q;
    inflight_d   = issue_w;
    occ_d        = occ_q + {1'b0, cap_w} - {1'b0, pop_w};
    wptr_d       = wptr_q ^ cap_w;
    rptr_d       = rptr_q ^ pop_w;
    if (mac_we_q) mac_addr_d = mac_addr_q + 8'd1;
    case (state_q)
      IDLE: if (bus_if.cmd_valid) begin
        write_d    = bus_if.cmd_write;
        addr_d     = bus_if.cmd_addr;
        nw_d       = bus_if.cmd_nw_m1;
        mac_addr_d = 8'd0;
        cnt_d      = 16'd0;
        err_d      = 1'b0;
        state_d    = bus_if.cmd_write ? FILL : SET_A;
      end
      FILL: if (bus_if.s_valid) begin
        mac_we_d = 1'b1;
        mac_wd_d = bus_if.s_data;
        cnt_d    = cnt_q + 16'd1;
        if (cnt_q[7:0] == nw_q) state_d = SET_A;
      end
      SET_A: begin
        mac_we_a_d = 1'b1;
        mac_wd_d   = addr_q;
        state_d    = SET_LEN;
      end
      SET_LEN: begin
        mac_we_len_d = 1'b1;
        mac_wd_d     = {write_q, 22'd0, nw_q, 1'b1};
        cnt_d        = 16'd0;
        state_d      = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus_if.mac_busy) state_d = WAIT_LO;
        else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else cnt_d = cnt_q + 16'd1;
      end
      WAIT_LO: if (!bus_if.mac_busy) begin
        if (write_q) state_d = FIN;
        else begin
          state_d    = DRAIN;
          mac_addr_d = 8'd0;
          cnt_d      = 16'd0;
          pop_d      = 8'd0;
        end
      end
      DRAIN: begin
        if (issue_w) begin
          mac_addr_d = mac_addr_q + 8'd1;
          cnt_d      = cnt_q + 16'd1;
        end
        if (pop_w) begin
          pop_d = pop_q + 8'd1;
          if (pop_q == nw_q) state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      nw_q         <= '0;
      mac_addr_q   <= '0;
      mac_wd_q     <= '0;
      mac_we_q     <= 1'b0;
      mac_we_a_q   <= 1'b0;
      mac_we_len_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      pop_q        <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      nw_q         <= nw_d;
      mac_addr_q   <= mac_addr_d;
      mac_wd_q     <= mac_wd_d;
      mac_we_q     <= mac_we_d;
      mac_we_a_q   <= mac_we_a_d;
      mac_we_len_q <= mac_we_len_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      pop_q        <= pop_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge clk_i) begin
      if (rst_i) skid_q[gi] <= '0;
      else if (cap_w && (wptr_q == 1'(gi))) skid_q[gi] <= bus_if.mac_rd;
    end
  end

  assign bus_if.cmd_ready  = (state_q == IDLE);
  assign bus_if.s_ready    = (state_q == FILL);
  assign bus_if.m_valid    = m_valid_w;
  assign bus_if.m_data     = skid_q[rptr_q];
  assign bus_if.done       = (state_q == FIN);
  assign bus_if.err        = (state_q == FIN) && err_q;
  assign bus_if.mac_wd     = mac_wd_q;
  assign bus_if.mac_addr   = mac_addr_q;
  assign bus_if.mac_we     = mac_we_q;
  assign bus_if.mac_we_a   = mac_we_a_q;
  assign bus_if.mac_we_len = mac_we_len_q;
endmodule
